// File: rtl/sc_speedtimer_pkg.sv
// -----------------------------------------------------------------------------
// sc_speedtimer_pkg
// Shared definitions for the shift-pacing timer that drives the background
// state machine's T0 input.
//   speedState_t      : FSM encoding of the timer (COUNTING=0, FIRED=1)
//   DEF_*             : default parameter values for a 50 MHz system
// -----------------------------------------------------------------------------
package sc_speedtimer_pkg;

  typedef enum logic {
    COUNTING = 1'b0,
    FIRED    = 1'b1
  } speedState_t;

  localparam int DEF_COUNT_WIDTH      = 24;
  localparam int DEF_BASE_PERIOD      = 12500000;  // 0.5 s of upcount pulses
  localparam int DEF_PERIOD_STEP      = 1000000;
  localparam int DEF_MIN_PERIOD       = 2500000;
  localparam int DEF_SHIFTS_PER_LEVEL = 16;
  localparam int DEF_LEVEL_WIDTH      = 4;
  localparam int DEF_MAX_LEVEL        = 9;

endpackage

// File: rtl/sc_levelcounter.sv
// -----------------------------------------------------------------------------
// sc_levelcounter
// Tracks consumed shifts and derives the game level and the current shift
// period. Every SHIFTS_PER_LEVEL consumes the level rises (saturating at
// MAX_LEVEL) and the period shrinks by PERIOD_STEP, floored at MIN_PERIOD.
// Ports:
//   SC_LEVELCOUNTER_CLOCK_50     in  : system clock
//   SC_LEVELCOUNTER_RESET_InLow  in  : asynchronous active-low reset
//   consumeStrobe                in  : one-cycle strobe, a shift was consumed
//   clearStrobe                  in  : synchronous clear back to level 0
//   level                        out : current level (registered)
//   period                       out : upcount pulses per shift (registered)
// -----------------------------------------------------------------------------
module sc_levelcounter
  import sc_speedtimer_pkg::*;
#(
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
  parameter int BASE_PERIOD      = DEF_BASE_PERIOD,
  parameter int PERIOD_STEP      = DEF_PERIOD_STEP,
  parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
  parameter int SHIFTS_PER_LEVEL = DEF_SHIFTS_PER_LEVEL,
  parameter int LEVEL_WIDTH      = DEF_LEVEL_WIDTH,
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL
) (
  input  logic                   SC_LEVELCOUNTER_CLOCK_50,
  input  logic                   SC_LEVELCOUNTER_RESET_InLow,
  input  logic                   consumeStrobe,
  input  logic                   clearStrobe,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic [COUNT_WIDTH-1:0] period
);

  localparam int SHIFT_W = (SHIFTS_PER_LEVEL > 1) ? $clog2(SHIFTS_PER_LEVEL) : 1;

  localparam logic [SHIFT_W-1:0]     SHIFT_LAST  = SHIFT_W'(SHIFTS_PER_LEVEL - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX   = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] PERIOD_BASE = COUNT_WIDTH'(BASE_PERIOD);
  localparam logic [COUNT_WIDTH-1:0] PERIOD_STP  = COUNT_WIDTH'(PERIOD_STEP);
  localparam logic [COUNT_WIDTH-1:0] PERIOD_MIN  = COUNT_WIDTH'(MIN_PERIOD);
  // One extra bit so MIN_PERIOD+PERIOD_STEP cannot wrap.
  localparam logic [COUNT_WIDTH:0]   FLOOR_PLUS_STEP =
    (COUNT_WIDTH+1)'(MIN_PERIOD) + (COUNT_WIDTH+1)'(PERIOD_STEP);

  logic [SHIFT_W-1:0] shiftCnt;

  // max(cur - PERIOD_STEP, MIN_PERIOD) evaluated without ever underflowing.
  function automatic logic [COUNT_WIDTH-1:0] nextPeriod(input logic [COUNT_WIDTH-1:0] cur);
    logic [COUNT_WIDTH-1:0] result;
    if ({1'b0, cur} < FLOOR_PLUS_STEP) begin
      result = PERIOD_MIN;
    end else begin
      result = cur - PERIOD_STP;
    end
    return result;
  endfunction

  always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or negedge SC_LEVELCOUNTER_RESET_InLow) begin
    if (!SC_LEVELCOUNTER_RESET_InLow) begin
      shiftCnt <= '0;
      level    <= '0;
      period   <= PERIOD_BASE;
    end else if (clearStrobe) begin
      shiftCnt <= '0;
      level    <= '0;
      period   <= PERIOD_BASE;
    end else if (consumeStrobe) begin
      if (shiftCnt == SHIFT_LAST) begin
        shiftCnt <= '0;
        // At the top level the shift counter keeps wrapping but nothing else moves.
        if (level < LEVEL_MAX) begin
          level  <= level + 1'b1;
          period <= nextPeriod(period);
        end
      end else begin
        shiftCnt <= shiftCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_speedtimer.sv
// -----------------------------------------------------------------------------
// sc_speedtimer
// Pacing stage for the background state machine. Counts upcount pulses
// against the current period and raises the shift request T0 (active low)
// when the period has elapsed. T0 is held until the state machine consumes it
// with its next upcount pulse; consumes feed the level counter, which speeds
// the game up as levels rise. The state machine's clear output restarts
// everything at level 0.
// Ports:
//   SC_SPEEDTIMER_CLOCK_50       in  : 50 MHz system clock
//   SC_SPEEDTIMER_RESET_InLow    in  : asynchronous active-low reset
//   SC_SPEEDTIMER_upcount_InLow  in  : count pulse, active low
//   SC_SPEEDTIMER_clear_InLow    in  : synchronous clear, active low
//   SC_SPEEDTIMER_T0_OutLow      out : shift request, active low, registered
//   SC_SPEEDTIMER_level_Out      out : current level, registered
// -----------------------------------------------------------------------------
module sc_speedtimer
  import sc_speedtimer_pkg::*;
#(
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
  parameter int BASE_PERIOD      = DEF_BASE_PERIOD,
  parameter int PERIOD_STEP      = DEF_PERIOD_STEP,
  parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
  parameter int SHIFTS_PER_LEVEL = DEF_SHIFTS_PER_LEVEL,
  parameter int LEVEL_WIDTH      = DEF_LEVEL_WIDTH,
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL
) (
  input  logic                   SC_SPEEDTIMER_CLOCK_50,
  input  logic                   SC_SPEEDTIMER_RESET_InLow,
  input  logic                   SC_SPEEDTIMER_upcount_InLow,
  input  logic                   SC_SPEEDTIMER_clear_InLow,
  output logic                   SC_SPEEDTIMER_T0_OutLow,
  output logic [LEVEL_WIDTH-1:0] SC_SPEEDTIMER_level_Out
);

  speedState_t            state;
  speedState_t            nextState;
  logic [COUNT_WIDTH-1:0] pulseCount;
  logic [COUNT_WIDTH-1:0] period;
  logic                   atLastPulse;
  logic                   consumeStrobe;
  logic                   clearStrobe;

  assign clearStrobe   = !SC_SPEEDTIMER_clear_InLow;
  assign atLastPulse   = (pulseCount == period - 1'b1);
  // Clear outranks a consume that arrives on the same edge.
  assign consumeStrobe = (state == FIRED) && !SC_SPEEDTIMER_upcount_InLow && !clearStrobe;

  sc_levelcounter #(
    .COUNT_WIDTH      (COUNT_WIDTH),
    .BASE_PERIOD      (BASE_PERIOD),
    .PERIOD_STEP      (PERIOD_STEP),
    .MIN_PERIOD       (MIN_PERIOD),
    .SHIFTS_PER_LEVEL (SHIFTS_PER_LEVEL),
    .LEVEL_WIDTH      (LEVEL_WIDTH),
    .MAX_LEVEL        (MAX_LEVEL)
  ) u_levelCounter (
    .SC_LEVELCOUNTER_CLOCK_50    (SC_SPEEDTIMER_CLOCK_50),
    .SC_LEVELCOUNTER_RESET_InLow (SC_SPEEDTIMER_RESET_InLow),
    .consumeStrobe               (consumeStrobe),
    .clearStrobe                 (clearStrobe),
    .level                       (SC_SPEEDTIMER_level_Out),
    .period                      (period)
  );

  // State register.
  always_ff @(posedge SC_SPEEDTIMER_CLOCK_50 or negedge SC_SPEEDTIMER_RESET_InLow) begin
    if (!SC_SPEEDTIMER_RESET_InLow) begin
      state <= COUNTING;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    if (clearStrobe) begin
      nextState = COUNTING;
    end else if (!SC_SPEEDTIMER_upcount_InLow) begin
      case (state)
        COUNTING: if (atLastPulse) nextState = FIRED;
        FIRED:    nextState = COUNTING;
        default:  nextState = COUNTING;
      endcase
    end
  end

  // Output logic: T0 is a pure decode of the state flop, so it drops out
  // asynchronously with reset and has no input-to-output path.
  always_comb begin
    SC_SPEEDTIMER_T0_OutLow = 1'b1;
    if (state == FIRED) begin
      SC_SPEEDTIMER_T0_OutLow = 1'b0;
    end
  end

  // Pulse counter. It parks at period-1 while FIRED and restarts at 0 on the
  // consume edge, so the consuming pulse is not part of the next interval.
  always_ff @(posedge SC_SPEEDTIMER_CLOCK_50 or negedge SC_SPEEDTIMER_RESET_InLow) begin
    if (!SC_SPEEDTIMER_RESET_InLow) begin
      pulseCount <= '0;
    end else if (clearStrobe) begin
      pulseCount <= '0;
    end else if (!SC_SPEEDTIMER_upcount_InLow) begin
      if (state == FIRED) begin
        pulseCount <= '0;
      end else if (!atLastPulse) begin
        pulseCount <= pulseCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sc_speedtimer.sv
// -----------------------------------------------------------------------------
// tb_sc_speedtimer
// Self-checking bench for sc_speedtimer with small parameters
// (BASE_PERIOD=4, PERIOD_STEP=1, MIN_PERIOD=2, SHIFTS_PER_LEVEL=2,
// MAX_LEVEL=3). A reference model keeps the number of pulses since the last
// consume/clear and the number of consumed shifts; level and period follow
// arithmetically from the consume count.
// -----------------------------------------------------------------------------
module tb_sc_speedtimer;

  localparam int CW    = 8;
  localparam int LW    = 4;
  localparam int BASE  = 4;
  localparam int STEP  = 1;
  localparam int MINP  = 2;
  localparam int SPL   = 2;
  localparam int MAXL  = 3;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          upcountInLow = 1'b1;
  logic          clearInLow = 1'b1;
  logic          t0Low;
  logic [LW-1:0] levelOut;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int mPulses   = 0;
  int mConsumed = 0;

  sc_speedtimer #(
    .COUNT_WIDTH      (CW),
    .BASE_PERIOD      (BASE),
    .PERIOD_STEP      (STEP),
    .MIN_PERIOD       (MINP),
    .SHIFTS_PER_LEVEL (SPL),
    .LEVEL_WIDTH      (LW),
    .MAX_LEVEL        (MAXL)
  ) dut (
    .SC_SPEEDTIMER_CLOCK_50      (clk),
    .SC_SPEEDTIMER_RESET_InLow   (rstN),
    .SC_SPEEDTIMER_upcount_InLow (upcountInLow),
    .SC_SPEEDTIMER_clear_InLow   (clearInLow),
    .SC_SPEEDTIMER_T0_OutLow     (t0Low),
    .SC_SPEEDTIMER_level_Out     (levelOut)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int mLevel();
    int l;
    l = mConsumed / SPL;
    if (l > MAXL) l = MAXL;
    return l;
  endfunction

  function automatic int mPeriod();
    int p;
    p = BASE - mLevel() * STEP;
    if (p < MINP) p = MINP;
    return p;
  endfunction

  function automatic int mT0();
    return (mPulses >= mPeriod()) ? 0 : 1;
  endfunction

  task automatic modelReset();
    mPulses   = 0;
    mConsumed = 0;
  endtask

  task automatic modelEdge(input logic up, input logic clr);
    if (clr) begin
      modelReset();
    end else if (up) begin
      if (mT0() == 0) begin
        mConsumed++;
        mPulses = 0;
      end else begin
        mPulses++;
      end
    end
  endtask

  // Entered at a negedge: drive inputs, let one active edge pass, check outputs.
  task automatic stepCycle(input logic up, input logic clr);
    upcountInLow = ~up;
    clearInLow   = ~clr;
    @(posedge clk);
    modelEdge(up, clr);
    @(negedge clk);
    checkVal("t0", int'(t0Low), mT0());
    checkVal("level", int'(levelOut), mLevel());
  endtask

  // Pulses every second cycle until T0 fires; returns the pulse count.
  task automatic measureFire(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      stepCycle(1'b1, 1'b0);
      n++;
      if (t0Low == 1'b0) break;
      stepCycle(1'b0, 1'b0);
    end
  endtask

  int n;
  int expSpace[8] = '{4, 4, 3, 3, 2, 2, 2, 2};
  int expLevel[8] = '{0, 1, 1, 2, 2, 3, 3, 3};
  int smState;
  int shifts;
  int fires;
  int cyc;
  int consumedAtStart;
  logic prevT0;
  logic up;

  initial begin
    #1 rstN = 1'b0;
    #1;
    checkVal("rst_t0", int'(t0Low), 1);
    checkVal("rst_level", int'(levelOut), 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    modelReset();

    // Test 1: first fire on the 4th pulse.
    for (int p = 1; p <= 4; p++) begin
      stepCycle(1'b1, 1'b0);
      checkVal("t1_pulse", int'(t0Low), (p == 4) ? 0 : 1);
      stepCycle(1'b0, 1'b0);
    end
    checkVal("t1_level", int'(levelOut), 0);

    // Test 2: T0 held without upcount, released by consume, refires after 4.
    for (int i = 0; i < 20; i++) stepCycle(1'b0, 1'b0);
    checkVal("t2_hold", int'(t0Low), 0);
    stepCycle(1'b1, 1'b0);
    checkVal("t2_consume", int'(t0Low), 1);
    measureFire(n);
    checkVal("t2_refire", n, 4);

    // Test 3: level progression and period clamping over 8 consumes.
    stepCycle(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      measureFire(n);
      checkVal("t3_spacing", n, expSpace[k]);
      stepCycle(1'b1, 1'b0);
      checkVal("t3_level", int'(levelOut), expLevel[k]);
    end

    // Test 4: clear together with upcount while FIRED at level 2.
    stepCycle(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      measureFire(n);
      stepCycle(1'b1, 1'b0);
    end
    measureFire(n);
    checkVal("t4_prefire_level", int'(levelOut), 2);
    stepCycle(1'b1, 1'b1);
    checkVal("t4_clear_t0", int'(t0Low), 1);
    checkVal("t4_clear_level", int'(levelOut), 0);
    measureFire(n);
    checkVal("t4_refire", n, 4);

    // Test 5: asynchronous reset while T0 is asserted.
    #2 rstN = 1'b0;
    #1;
    checkVal("t5_async_t0", int'(t0Low), 1);
    checkVal("t5_async_level", int'(levelOut), 0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    measureFire(n);
    checkVal("t5_refire", n, 4);
    stepCycle(1'b1, 1'b0);

    // Test 6: closed loop with an emulated CHECK/COUNT/SHIFT state machine.
    stepCycle(1'b0, 1'b1);
    smState = 0;
    shifts = 0;
    fires = 0;
    cyc = 0;
    consumedAtStart = mConsumed;
    prevT0 = t0Low;
    while (shifts < 50 && cyc < 20000) begin
      up = (smState == 1);
      stepCycle(up, 1'b0);
      cyc++;
      if (prevT0 == 1'b1 && t0Low == 1'b0) fires++;
      prevT0 = t0Low;
      case (smState)
        0:       smState = (t0Low == 1'b0) ? 2 : 1;
        2:       begin shifts++; smState = 1; end
        default: smState = 0;
      endcase
    end
    stepCycle(1'b1, 1'b0);
    checkVal("t6_shifts", shifts, 50);
    checkVal("t6_fires", fires, shifts);
    checkVal("t6_consumes", mConsumed - consumedAtStart, shifts);
    checkVal("t6_released", int'(t0Low), 1);

    // Random phase: arbitrary upcount/clear traffic checked every cycle.
    for (int i = 0; i < 600; i++) begin
      stepCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
